// File: rtl/axis_s2mm_burst_wr.sv
// axis_s2mm_burst_wr
//   S2MM write engine. It takes a 256-bit AXI-Stream capture feed and writes it
//   to memory as fixed-length INCR bursts. The bursts fill a circular buffer
//   [base, base + floor(cap_size)), and the write address returns to base after
//   each full pass. Only one burst is outstanding at a time.
//
// Ports
//   axi_aclk, axi_rstb         clock, async active-low reset
//   write_start                1-cycle pulse: latch base/size and begin capture (ignored while busy)
//   write_reset                stop at the next burst boundary (ignored while idle)
//   start_address, cap_size    buffer base (burst-span aligned) and size in bytes
//   axi_aw*                    AXI4 write-address channel (constant length/size/burst/cache)
//   axi_w*                     AXI4 write-data channel, data/strobe passed through from the stream
//   axi_b*                     AXI4 write-response channel
//   s_axis_*                   capture stream (tlast is not used)
//   current_addr               awaddr of the most recently accepted burst
//   run_cycles                 completed full passes over the buffer, modulo 256
//   wr_s2mm_err                sticky: a non-OKAY write response was seen since write_start
//   busy                       engine is not idle
//
// Build option
//   S2MM_ONESHOT_EN            when defined, stop after one full pass instead of wrapping
module axis_s2mm_burst_wr #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_rstb,
  input  logic                  write_start,
  input  logic                  write_reset,
  input  logic [ADDR_W-1:0]     start_address,
  input  logic [31:0]           cap_size,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic [3:0]            axi_awcache,
  output logic [2:0]            axi_awprot,
  output logic [3:0]            axi_awid,
  output logic [3:0]            axi_awuser,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_W-1:0]     current_addr,
  output logic [7:0]            run_cycles,
  output logic                  wr_s2mm_err,
  output logic                  busy
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BSPAN  = BURST_LEN * BYTES;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [31:0]       SPAN_MASK = 32'(BSPAN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t              state;
  state_t              state_n;

  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   end_addr;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_inc;
  logic [BEAT_W-1:0]   beat;
  logic                stop_q;

  logic [31:0]         cap_floor;
  logic                start_ok;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                at_end;
  logic                pass_stop;

  // Configuration qualification: size is floored to whole bursts
  assign cap_floor = cap_size & ~SPAN_MASK;
  assign start_ok  = (state == ST_IDLE) && write_start && (cap_floor >= 32'(BSPAN));

  // Channel handshakes as seen from this engine's state
  assign aw_hs = (state == ST_ADDR) && axi_awready;
  assign w_hs  = (state == ST_DATA) && s_axis_tvalid && axi_wready;
  assign b_hs  = (state == ST_RESP) && axi_bvalid;

  // Next burst address and end-of-buffer detection
  assign addr_inc = addr + ADDR_W'(BSPAN);
  assign at_end   = (addr_inc == end_addr);

`ifdef S2MM_ONESHOT_EN
  assign pass_stop = at_end;
`else
  assign pass_stop = 1'b0;
`endif

  // Constant write-address attributes
  assign axi_awaddr  = addr;
  assign axi_awlen   = 8'(BURST_LEN - 1);
  assign axi_awsize  = 3'($clog2(BYTES));
  assign axi_awburst = 2'b01;
  assign axi_awcache = 4'b0011;
  assign axi_awprot  = 3'b000;
  assign axi_awid    = 4'b0000;
  assign axi_awuser  = 4'b0000;

  // Stream payload goes straight onto the W channel
  assign axi_wdata = s_axis_tdata;
  assign axi_wstrb = s_axis_tkeep;

  assign busy = (state != ST_IDLE);

  // State register
  always_ff @(posedge axi_aclk or negedge axi_rstb) begin
    if (!axi_rstb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and channel control decode
  always_comb begin
    state_n       = state;
    axi_awvalid   = 1'b0;
    axi_wvalid    = 1'b0;
    axi_wlast     = 1'b0;
    s_axis_tready = 1'b0;
    axi_bready    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_n = ST_ADDR;
        end
      end
      ST_ADDR: begin
        axi_awvalid = 1'b1;
        if (axi_awready) begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        axi_wvalid    = s_axis_tvalid;
        s_axis_tready = axi_wready;
        axi_wlast     = (beat == LAST_BEAT);
        if (w_hs && (beat == LAST_BEAT)) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          // A stop request arriving with the response still ends the run here
          state_n = (stop_q || write_reset || pass_stop) ? ST_IDLE : ST_ADDR;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Buffer pointer, beat counter and status registers
  always_ff @(posedge axi_aclk or negedge axi_rstb) begin
    if (!axi_rstb) begin
      base_addr    <= '0;
      end_addr     <= '0;
      addr         <= '0;
      beat         <= '0;
      stop_q       <= 1'b0;
      current_addr <= '0;
      run_cycles   <= '0;
      wr_s2mm_err  <= 1'b0;
    end else begin
      if (start_ok) begin
        base_addr   <= start_address;
        end_addr    <= start_address + ADDR_W'(cap_floor);
        addr        <= start_address;
        stop_q      <= 1'b0;
        run_cycles  <= '0;
        wr_s2mm_err <= 1'b0;
      end

      if (busy && write_reset) begin
        stop_q <= 1'b1;
      end

      if (aw_hs) begin
        current_addr <= addr;
        beat         <= '0;
      end

      if (w_hs) begin
        beat <= beat + BEAT_W'(1);
      end

      if (b_hs) begin
        if (axi_bresp != 2'b00) begin
          wr_s2mm_err <= 1'b1;
        end
        if (at_end) begin
          addr       <= base_addr;
          run_cycles <= run_cycles + 8'd1;
        end else begin
          addr <= addr_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_s2mm_burst_wr.sv
// tb_axis_s2mm_burst_wr
//   Randomised bench for axis_s2mm_burst_wr. A stream source, an AXI slave and a
//   monitor run alongside the test sequence. Each run computes the expected burst
//   addresses, pass counts and error flags from the buffer geometry and queues
//   them; each generated stream beat is queued as expected write data. The
//   monitor pops and compares whenever the DUT completes a handshake.
module tb_axis_s2mm_burst_wr;

  localparam int unsigned DW   = 256;
  localparam int unsigned AW   = 32;
  localparam int unsigned BY   = DW / 8;
  localparam int unsigned SPAN = 512;

  logic              axi_aclk;
  logic              axi_rstb;
  logic              write_start;
  logic              write_reset;
  logic [AW-1:0]     start_address;
  logic [31:0]       cap_size;
  logic [AW-1:0]     axi_awaddr;
  logic [7:0]        axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;
  logic [3:0]        axi_awcache;
  logic [2:0]        axi_awprot;
  logic [3:0]        axi_awid;
  logic [3:0]        axi_awuser;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [DW-1:0]     axi_wdata;
  logic [BY-1:0]     axi_wstrb;
  logic              axi_wlast;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [DW-1:0]     s_axis_tdata;
  logic [BY-1:0]     s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [AW-1:0]     current_addr;
  logic [7:0]        run_cycles;
  logic              wr_s2mm_err;
  logic              busy;

  axis_s2mm_burst_wr dut (
    .axi_aclk      (axi_aclk),
    .axi_rstb      (axi_rstb),
    .write_start   (write_start),
    .write_reset   (write_reset),
    .start_address (start_address),
    .cap_size      (cap_size),
    .axi_awaddr    (axi_awaddr),
    .axi_awlen     (axi_awlen),
    .axi_awsize    (axi_awsize),
    .axi_awburst   (axi_awburst),
    .axi_awcache   (axi_awcache),
    .axi_awprot    (axi_awprot),
    .axi_awid      (axi_awid),
    .axi_awuser    (axi_awuser),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wlast     (axi_wlast),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .axi_bresp     (axi_bresp),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .current_addr  (current_addr),
    .run_cycles    (run_cycles),
    .wr_s2mm_err   (wr_s2mm_err),
    .busy          (busy)
  );

  initial begin
    axi_aclk = 1'b0;
    forever #5 axi_aclk = ~axi_aclk;
  end

  int  n_pass;
  int  n_total;
  int  tot_aw;
  int  tot_w;
  int  tot_t;
  int  tot_b;
  int  tot_wlast;
  int  b_issued;
  int  err_at;
  bit  stall;

  logic [31:0]      exp_aw[$];
  logic [7:0]       exp_rc[$];
  bit               exp_err[$];
  logic [DW+BY-1:0] exp_w[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got event/timeout, expected none", name);
  endtask

  task automatic new_beat(output logic [DW-1:0] d, output logic [BY-1:0] k);
    for (int i = 0; i < DW / 32; i++) begin
      d[32*i +: 32] = $urandom;
    end
    k = BY'($urandom);
    exp_w.push_back({d, k});
  endtask

  // Capture stream: a new random beat after every accepted one, held until taken
  task automatic source();
    logic [DW-1:0] d;
    logic [BY-1:0] k;
    int            seen;
    seen = 0;
    new_beat(d, k);
    forever begin
      @(posedge axi_aclk);
      #1;
      if (tot_t != seen) begin
        seen = tot_t;
        new_beat(d, k);
        s_axis_tvalid = 1'b0;
      end
      if (!s_axis_tvalid) begin
        s_axis_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      s_axis_tdata = d;
      s_axis_tkeep = k;
    end
  endtask

  // Memory-side slave: random AW/W back-pressure, one B per completed burst
  task automatic slave();
    forever begin
      @(posedge axi_aclk);
      #1;
      axi_awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      axi_wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (axi_bvalid && (tot_b == b_issued)) begin
        axi_bvalid = 1'b0;
      end
      if (!axi_bvalid && (tot_wlast > b_issued) && (!stall || ($urandom_range(0, 1) == 1))) begin
        b_issued++;
        axi_bvalid = 1'b1;
        axi_bresp  = (b_issued == err_at) ? 2'b10 : 2'b00;
      end
    end
  endtask

  // Observes handshakes half a cycle before the edge that completes them
  task automatic monitor();
    logic [DW+BY-1:0] ew;
    logic [31:0]      ca_exp;
    bit               ca_pend;
    bit               b_pend;
    bit               last_exp;
    ca_pend = 1'b0;
    b_pend  = 1'b0;
    ca_exp  = '0;
    forever begin
      @(negedge axi_aclk);
      if (!axi_rstb) begin
        ca_pend = 1'b0;
        b_pend  = 1'b0;
        continue;
      end
      if (ca_pend) begin
        chk("current_addr", current_addr, ca_exp);
        ca_pend = 1'b0;
      end
      if (b_pend) begin
        if (exp_rc.size() == 0) begin
          fail_now("unexpected_b");
        end else begin
          chk("run_cycles", run_cycles, exp_rc.pop_front());
          chk("err_flag", wr_s2mm_err, exp_err.pop_front());
        end
        b_pend = 1'b0;
      end
      if (axi_awvalid && axi_awready) begin
        if (exp_aw.size() == 0) begin
          fail_now("unexpected_aw");
        end else begin
          ca_exp = exp_aw.pop_front();
          chk("awaddr", axi_awaddr, ca_exp);
          ca_pend = 1'b1;
        end
        chk("aw_fields", {axi_awlen, axi_awsize, axi_awburst, axi_awcache, axi_awprot, axi_awid, axi_awuser},
            {8'd15, 3'b101, 2'b01, 4'b0011, 3'b000, 4'h0, 4'h0});
        tot_aw++;
      end
      if (axi_wvalid && axi_wready) begin
        last_exp = ((tot_w % 16) == 15);
        if (exp_w.size() == 0) begin
          fail_now("unexpected_w");
        end else begin
          ew = exp_w.pop_front();
          chk("w_beat", {axi_wdata, axi_wstrb, axi_wlast}, {ew, last_exp});
        end
        tot_w++;
        if (last_exp) begin
          tot_wlast++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        tot_t++;
      end
      if (axi_bvalid && axi_bready) begin
        tot_b++;
        b_pend = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge axi_aclk);
      #1;
    end
    if (!ok) begin
      fail_now(name);
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [31:0] cap);
    @(posedge axi_aclk);
    #1;
    start_address = base;
    cap_size      = cap;
    write_start   = 1'b1;
    @(posedge axi_aclk);
    #1;
    write_start = 1'b0;
  endtask

  // One capture run: stop requested at beat 5 of burst stop_burst (0-based);
  // err_rel selects which burst of the run (1-based) gets SLVERR, 0 for none
  task automatic run(input logic [31:0] base, input logic [31:0] cap, input int stop_burst,
                     input bit stl, input int err_rel);
    int          nb;
    int          nexp;
    int          aw0;
    int          b0;
    bit          esticky;
    bit          hit;
    logic [31:0] off;
    logic [7:0]  rc;

    wait_idle("idle_before_run");
    exp_aw.delete();
    exp_rc.delete();
    exp_err.delete();
    stall  = stl;
    nb     = int'(cap >> 9);
    aw0    = tot_aw;
    b0     = tot_b;
    err_at = (err_rel > 0) ? (b_issued + err_rel) : 0;

    if (nb == 0) begin
      pulse_start(base, cap);
      chk("small_cap_busy", busy, 1'b0);
      repeat (20) @(posedge axi_aclk);
      #1;
      chk("small_cap_idle", busy, 1'b0);
      chk("small_cap_no_aw", tot_aw - aw0, 0);
      return;
    end

    nexp = stop_burst + 1;
`ifdef S2MM_ONESHOT_EN
    if (nexp > nb) nexp = nb;
`endif
    esticky = 1'b0;
    for (int j = 1; j <= nexp; j++) begin
      off = 32'((j - 1) % nb) * 32'(SPAN);
      exp_aw.push_back(base + off);
`ifdef S2MM_ONESHOT_EN
      rc = (j == nb) ? 8'd1 : 8'd0;
`else
      rc = 8'(j / nb);
`endif
      exp_rc.push_back(rc);
      if (err_rel > 0 && j == err_rel) esticky = 1'b1;
      exp_err.push_back(esticky);
    end

    pulse_start(base, cap);
    chk("start_busy", busy, 1'b1);
    chk("start_runs_clear", run_cycles, 8'd0);
    chk("start_err_clear", wr_s2mm_err, 1'b0);

    hit = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (!busy) begin
        hit = 1'b1;
        break;
      end
      if ((tot_aw - aw0 == stop_burst + 1) && ((tot_w % 16) == 5)) begin
        write_reset = 1'b1;
        @(posedge axi_aclk);
        #1;
        write_reset = 1'b0;
        hit = 1'b1;
        break;
      end
      @(posedge axi_aclk);
      #1;
    end
    if (!hit) fail_now("stop_point_timeout");

    wait_idle("idle_after_stop");
    repeat (30) @(posedge axi_aclk);
    #1;
    chk("run_aw_count", tot_aw - aw0, nexp);
    chk("run_b_count", tot_b - b0, nexp);
    chk("run_end_idle", busy, 1'b0);
    chk("run_aw_all_seen", exp_aw.size(), 0);
  endtask

  initial begin
    axi_rstb      = 1'b0;
    write_start   = 1'b0;
    write_reset   = 1'b0;
    start_address = '0;
    cap_size      = '0;
    axi_awready   = 1'b0;
    axi_wready    = 1'b0;
    axi_bvalid    = 1'b0;
    axi_bresp     = 2'b00;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    n_pass = 0;  n_total = 0;
    tot_aw = 0;  tot_w = 0;  tot_t = 0;  tot_b = 0;  tot_wlast = 0;
    b_issued = 0;  err_at = 0;  stall = 1'b0;

    fork
      monitor();
      slave();
      source();
    join_none

    repeat (3) @(posedge axi_aclk);
    #1;
    chk("rst_ctrl", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, s_axis_tready, busy, wr_s2mm_err}, 7'b0);
    chk("rst_current_addr", current_addr, 32'h0);
    chk("rst_run_cycles", run_cycles, 8'h0);
    @(negedge axi_aclk);
    axi_rstb = 1'b1;
    repeat (2) @(posedge axi_aclk);

    // Four-burst ring, continuous flow, wraps once before stopping
    run(32'h1000_0000, 32'h0000_0800, 5, 1'b0, 0);
    // Back-pressure on both sides
    run(32'h2000_0000, 32'h0000_0A00, 6, 1'b1, 0);
    // Error on the second burst stays sticky
    run(32'h1000_0000, 32'h0000_0800, 3, 1'b1, 2);
    // Size below one burst is rejected; size just under two bursts floors to one
    run(32'h1800_0000, 32'h0000_01FF, 0, 1'b0, 0);
    run(32'h1800_0000, 32'h0000_03FF, 3, 1'b1, 0);
    // Two-burst ring: wraps or stops after one pass depending on the build
    run(32'h0400_0000, 32'h0000_0400, 3, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      run($urandom_range(0, 32'h7000_0000) & 32'hFFFF_FE00, $urandom_range(32'h200, 32'h1800),
          $urandom_range(1, 5), 1'b1, $urandom_range(0, 3));
    end

    // Async reset in the middle of a burst drops the channel controls at once
    wait_idle("idle_before_arst");
    stall = 1'b0;
    exp_aw.delete();
    exp_rc.delete();
    exp_err.delete();
    exp_aw.push_back(32'h3000_0000);
    pulse_start(32'h3000_0000, 32'h0000_0800);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ((tot_w % 16) == 8) begin
          hit = 1'b1;
          break;
        end
        @(posedge axi_aclk);
        #1;
      end
      if (!hit) fail_now("arst_beat_timeout");
    end
    #2;
    axi_rstb = 1'b0;
    #1;
    chk("arst_ctrl", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, s_axis_tready, busy}, 6'b0);
    chk("arst_runs", {run_cycles, current_addr}, 40'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
